// File: rtl/wb_snoop_display_scan_pkg.sv
// Shared constants for the writeback snoop display:
// glyph table, special glyphs, digit count, register indices.
package wb_snoop_display_scan_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Element i is the {g,f,e,d,c,b,a} glyph of hex digit i.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [4:0] REG_T0 = 5'd8;
  localparam logic [4:0] REG_T1 = 5'd9;
  localparam logic [4:0] REG_T2 = 5'd10;
  localparam logic [4:0] REG_S0 = 5'd16;
  localparam logic [4:0] REG_S1 = 5'd17;
  localparam logic [4:0] REG_S2 = 5'd18;
  localparam logic [4:0] REG_S3 = 5'd19;
  localparam logic [4:0] REG_S4 = 5'd20;

endpackage

// File: rtl/wb_snoop_display_scan_decode.sv
// hex_seg7_decode: combinational nibble -> segment glyph.
// Ports: nibble_i (4b hex digit), seg_o (7b {g,f,e,d,c,b,a}).
module hex_seg7_decode
  import wb_snoop_display_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPH[nibble_i];

endmodule

// File: rtl/wb_snoop_display_scan.sv
// Snoops the writeback port, captures one register, scans it onto a
// 6-digit muxed 7-seg display. Ports: clk/reset, writeback bundle,
// freeze/blank_lz controls, seg/digit_sel display, capture status.
module wb_snoop_display_scan
  import wb_snoop_display_scan_pkg::*;
#(
  parameter logic [4:0] WATCH_REG = REG_S1,
  parameter int         SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        freeze,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [5:0]  digit_sel,
  output logic [23:0] captured,
  output logic        capture_valid,
  output logic [7:0]  update_count
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic [23:0]   cap_q, cap_d;
  logic          valid_q, valid_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    sel_q, sel_d;

  logic          tick;
  logic          hit;
  logic [23:0]   hi;
  logic [6:0]    glyph;

  assign tick = (div_cnt_q == DIV_LAST);
  assign hit  = reg_write & (write_reg == WATCH_REG)
              & (WATCH_REG != 5'd0) & ~freeze;

  // Nibbles k..5 of the held value; zero means leading zeros.
  assign hi = cap_q >> {digit_idx_q, 2'b00};

  hex_seg7_decode u_dec (
    .nibble_i (hi[3:0]),
    .seg_o    (glyph)
  );

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (tick)
      digit_idx_d = (digit_idx_q == IDX_LAST) ? 3'd0
                                              : digit_idx_q + 3'd1;
    cap_d   = cap_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (hit) begin
      cap_d   = write_data[23:0];
      valid_d = 1'b1;
      cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Select and segments come from the same pre-edge state, so they
  // switch together and never mix two digits.
  always_comb begin
    sel_d = 6'b000001 << digit_idx_q;
    if (!valid_q)
      seg_d = SEG_DASH;
    else if (blank_lz && digit_idx_q != 3'd0 && hi == 24'd0)
      seg_d = SEG_BLANK;
    else
      seg_d = glyph;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 3'd0;
      cap_q       <= 24'd0;
      valid_q     <= 1'b0;
      cnt_q       <= 8'd0;
      seg_q       <= SEG_DASH;
      sel_q       <= 6'b000001;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      cap_q       <= cap_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
    end
  end

  assign seg           = seg_q;
  assign digit_sel     = sel_q;
  assign captured      = cap_q;
  assign capture_valid = valid_q;
  assign update_count  = cnt_q;

endmodule

// File: tb/tb_wb_snoop_display_scan.sv
// Bench for wb_snoop_display_scan: table vectors, scan sequences,
// and random traffic against a cycle-count reference model.
module tb_wb_snoop_display_scan;

  localparam int DIV = 4;

  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        freeze;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [5:0]  digit_sel;
  logic [23:0] captured;
  logic        capture_valid;
  logic [7:0]  update_count;

  always #5 clk = ~clk;

  wb_snoop_display_scan #(
    .WATCH_REG (5'd17),
    .SCAN_DIV  (DIV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .freeze        (freeze),
    .blank_lz      (blank_lz),
    .seg           (seg),
    .digit_sel     (digit_sel),
    .captured      (captured),
    .capture_valid (capture_valid),
    .update_count  (update_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(int k, logic [23:0] v,
                                           logic ok, logic bl);
    logic [23:0] up;
    up = v >> (4 * k);
    if (!ok) return 7'h40;
    if (bl && k != 0 && up == 24'd0) return 7'h00;
    return HEX[int'(up & 24'hF)];
  endfunction

  // Model: t = edges since reset, digit = (t / DIV) mod 6.
  int          m_t;
  logic [23:0] m_cap;
  logic        m_val;
  int          m_cnt;
  logic [6:0]  e_seg;
  logic [5:0]  e_sel;
  bit          chk_en = 0;

  always @(posedge clk) begin
    int k;
    if (reset) begin
      m_t = 0; m_cap = 0; m_val = 0; m_cnt = 0;
      e_seg = 7'h40; e_sel = 6'b000001;
    end else begin
      k = (m_t / DIV) % 6;
      e_sel = 6'(1 << k);
      e_seg = ref_glyph(k, m_cap, m_val, blank_lz);
      m_t++;
      if (reg_write && write_reg == 5'd17 && !freeze) begin
        m_cap = write_data[23:0];
        m_val = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb_seg", seg, e_seg);
      chk("sb_sel", digit_sel, e_sel);
      chk("sb_cap", captured, m_cap);
      chk("sb_valid", capture_valid, m_val);
      chk("sb_cnt", update_count, m_cnt);
    end
  end

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        fz;
    logic [23:0] e_cap;
    int          e_cnt;
  } vec_t;

  vec_t vt [8];

  task automatic scan_check(string nm, logic [5:0][6:0] exp);
    logic [6:0] got [6];
    logic [5:0] seen;
    seen = '0;
    for (int k = 0; k < 6; k++) got[k] = 7'h00;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6 * DIV + 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++)
        if (digit_sel == 6'(1 << k)) begin
          got[k] = seg;
          seen[k] = 1'b1;
        end
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_d%0d", nm, k),
          seen[k] ? {25'd0, got[k]} : 32'hDEAD_0000,
          {25'd0, exp[k]});
  endtask

  task automatic wr(logic [4:0] r, logic [31:0] d);
    @(negedge clk);
    reg_write = 1'b1; write_reg = r; write_data = d;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  initial begin
    int found;
    logic [31:0] last;
    vt[0] = '{1'b1, 5'd17, 32'hAB123456, 1'b0, 24'h123456, 1};
    vt[1] = '{1'b1, 5'd17, 32'h00FFFFFF, 1'b1, 24'h123456, 1};
    vt[2] = '{1'b1, 5'd16, 32'hDEADBEEF, 1'b0, 24'h123456, 1};
    vt[3] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 24'h123456, 1};
    vt[4] = '{1'b0, 5'd17, 32'h99999999, 1'b0, 24'h123456, 1};
    vt[5] = '{1'b1, 5'd17, 32'h000000A0, 1'b0, 24'h0000A0, 2};
    vt[6] = '{1'b1, 5'd17, 32'h00000000, 1'b0, 24'h000000, 3};
    vt[7] = '{1'b1, 5'd17, 32'hFF654321, 1'b0, 24'h654321, 4};

    reset = 1'b1; reg_write = 1'b0; write_reg = '0;
    write_data = '0; freeze = 1'b0; blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", seg, 7'h40);
    chk("rst_sel", digit_sel, 6'b000001);
    chk("rst_cap", captured, 24'd0);
    chk("rst_valid", capture_valid, 1'b0);
    chk("rst_cnt", update_count, 8'd0);
    chk_en = 1;
    reset = 1'b0;

    repeat (30) @(negedge clk);
    chk("idle_valid", capture_valid, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reg_write = vt[i].rw; write_reg = vt[i].wr;
      write_data = vt[i].wd; freeze = vt[i].fz;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cap", i), captured, vt[i].e_cap);
      chk($sformatf("vec%0d_cnt", i), update_count, vt[i].e_cnt);
    end
    @(negedge clk);
    reg_write = 1'b0; freeze = 1'b0;

    wr(5'd17, 32'hAB123456);
    scan_check("hex", {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D});
    blank_lz = 1'b1;
    wr(5'd17, 32'h000000A0);
    scan_check("blkA0", {7'h00, 7'h00, 7'h00, 7'h00, 7'h77, 7'h3F});
    wr(5'd17, 32'h00000000);
    scan_check("blk0", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F});
    blank_lz = 1'b0;

    last = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      last = $urandom;
      reg_write = 1'b1; write_reg = 5'd17; write_data = last;
    end
    @(negedge clk);
    reg_write = 1'b0;
    chk("sat_cnt", update_count, 8'd255);
    chk("sat_cap", captured, last[23:0]);

    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if ((m_t / DIV) % 6 == 3) found = 1;
    end
    chk("midscan_found", found, 1);
    reset = 1'b1; reg_write = 1'b1;
    write_reg = 5'd17; write_data = 32'h00777777;
    @(posedge clk);
    #1;
    chk("mid_cap", captured, 24'd0);
    chk("mid_valid", capture_valid, 1'b0);
    chk("mid_cnt", update_count, 8'd0);
    chk("mid_seg", seg, 7'h40);
    chk("mid_sel", digit_sel, 6'b000001);
    @(negedge clk);
    reset = 1'b0; reg_write = 1'b0;
    repeat (30) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reg_write = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: write_reg = 5'd17;
        2: write_reg = 5'd16;
        default: write_reg = 5'($urandom);
      endcase
      write_data = $urandom;
      if ($urandom_range(0, 1) == 1)
        write_data = write_data & 32'h0000_0FFF;
      freeze = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) reset = 1'b1;
      else reset = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0; reg_write = 1'b0; freeze = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
